// File: rtl/ofm_drain_streamer_if.sv
// Bundle between the OFM drain streamer, OFM RAM read port A and the element sink.
interface ofm_drain_streamer_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LANES      = 16,
    parameter int unsigned ADDR_WIDTH = 14
);
    logic [ADDR_WIDTH-1:0]       ram_addr;
    logic                        ram_addr_valid;
    logic [LANES*DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0]       m_data;
    logic                        m_valid;
    logic                        m_ready;
    logic                        m_last;

    modport master (
        output ram_addr, ram_addr_valid, m_data, m_valid, m_last,
        input  ram_rdata, m_ready
    );

    modport slave (
        input  ram_addr, ram_addr_valid, m_data, m_valid, m_last,
        output ram_rdata, m_ready
    );
endinterface

// File: rtl/ofm_drain_streamer.sv
// Drains the OFM RAM word by word and serializes each word into a one-element stream.
// Optional ReLU on the output elements is enabled by defining OFM_DRAIN_RELU_EN.
module ofm_drain_streamer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LANES      = 16,
    parameter int unsigned OFM_SIZE   = 32,
    parameter int unsigned NO_FILTER  = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(OFM_SIZE*OFM_SIZE*NO_FILTER)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    ofm_drain_streamer_if.master   bus
);
    localparam int unsigned TOTAL_WORDS = OFM_SIZE*OFM_SIZE*NO_FILTER/LANES;
    localparam int unsigned CNT_W       = $clog2(TOTAL_WORDS + 1);
    localparam int unsigned LANE_W      = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef logic [LANES-1:0][DATA_WIDTH-1:0] word_t;

    logic [1:0]            state, state_nxt;
    logic [CNT_W-1:0]      word_cnt;
    logic [CNT_W-1:0]      issue_cnt_c;
    logic                  issue_c;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic                  ram_addr_valid_q;
    logic                  rd_pend;
    logic                  rd_last;
    logic                  busy_q, done_q;

    word_t                 rdata_w;
    word_t                 ser_data, pf_data;
    logic                  ser_full, ser_last;
    logic                  pf_full, pf_last;
    logic [LANE_W-1:0]     lane_idx;

    logic                  xfer_c, ser_drain_c, xfer_last_c, cap_ser_c, lane_end_c;
    logic [DATA_WIDTH-1:0] elem_c;

    assign rdata_w     = bus.ram_rdata;
    assign lane_end_c  = (lane_idx == LANE_W'(LANES - 1));
    assign xfer_c      = ser_full && bus.m_ready;
    assign ser_drain_c = xfer_c && lane_end_c;
    assign xfer_last_c = ser_drain_c && ser_last;
    // Returning word goes straight to SER when SER is free (or freeing) and nothing is queued ahead of it.
    assign cap_ser_c   = rd_pend && (!ser_full || (ser_drain_c && !pf_full));

    // Next-state and read-issue decision
    always_comb begin
        state_nxt   = state;
        issue_c     = 1'b0;
        issue_cnt_c = word_cnt;
        case (state)
            S_IDLE: begin
                issue_cnt_c = '0;
                if (start) begin
                    issue_c   = 1'b1;
                    state_nxt = (TOTAL_WORDS == 1) ? S_FLUSH : S_RUN;
                end
            end
            S_RUN: begin
                if (!ram_addr_valid_q && !rd_pend && !pf_full &&
                    (word_cnt < CNT_W'(TOTAL_WORDS))) begin
                    issue_c = 1'b1;
                    if (word_cnt == CNT_W'(TOTAL_WORDS - 1)) begin
                        state_nxt = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (xfer_last_c) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Read issue, prefetch and serializer datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt         <= '0;
            ram_addr_q       <= '0;
            ram_addr_valid_q <= 1'b0;
            rd_pend          <= 1'b0;
            rd_last          <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            ser_data         <= '0;
            ser_full         <= 1'b0;
            ser_last         <= 1'b0;
            lane_idx         <= '0;
            pf_data          <= '0;
            pf_full          <= 1'b0;
            pf_last          <= 1'b0;
        end else begin
            ram_addr_valid_q <= issue_c;
            rd_pend          <= ram_addr_valid_q;
            busy_q           <= (state_nxt == S_RUN) || (state_nxt == S_FLUSH);
            done_q           <= (state_nxt == S_DONE);

            if (state == S_IDLE) begin
                word_cnt <= '0;
            end
            if (issue_c) begin
                word_cnt   <= issue_cnt_c + CNT_W'(1);
                ram_addr_q <= ADDR_WIDTH'(32'(issue_cnt_c) * LANES);
                rd_last    <= (issue_cnt_c == CNT_W'(TOTAL_WORDS - 1));
            end

            if (ser_drain_c) begin
                lane_idx <= '0;
                if (pf_full) begin
                    ser_data <= pf_data;
                    ser_last <= pf_last;
                    pf_full  <= 1'b0;
                end else begin
                    ser_full <= 1'b0;
                end
            end else if (xfer_c) begin
                lane_idx <= lane_idx + LANE_W'(1);
            end

            if (cap_ser_c) begin
                ser_data <= rdata_w;
                ser_full <= 1'b1;
                ser_last <= rd_last;
                lane_idx <= '0;
            end else if (rd_pend) begin
                pf_data <= rdata_w;
                pf_full <= 1'b1;
                pf_last <= rd_last;
            end
        end
    end

`ifdef OFM_DRAIN_RELU_EN
    always_comb begin
        elem_c = ser_data[lane_idx];
        if (elem_c[DATA_WIDTH-1]) begin
            elem_c = '0;
        end
    end
`else
    assign elem_c = ser_data[lane_idx];
`endif

    assign bus.ram_addr       = ram_addr_q;
    assign bus.ram_addr_valid = ram_addr_valid_q;
    assign bus.m_valid        = ser_full;
    assign bus.m_data         = ser_full ? elem_c : '0;
    assign bus.m_last         = ser_full && lane_end_c && ser_last;
    assign busy               = busy_q;
    assign done               = done_q;
endmodule
